// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces the 2-bit coin sensor, queues accepted coins
// in a small FIFO and releases them as gap-spaced one-hot b1/b2/b3 pulses.
module coin_acceptor #(
    parameter int DEBOUNCE = 4,
    parameter int RELEASE  = 2,
    parameter int GAP      = 2,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sense,
    input  logic       busy,
    output logic       b1,
    output logic       b2,
    output logic       b3,
    output logic       reject,
    output logic [3:0] pending
);

    // state    | meaning
    // IDLE     | no coin in the sensor, waiting for a non-zero code
    // QUAL     | non-zero code seen, counting how long it stays stable
    // WAIT_REL | coin captured, waiting for RELEASE quiet cycles before re-arming
    typedef enum logic [1:0] {IDLE, QUAL, WAIT_REL} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0]    DEB_L   = 4'(DEBOUNCE);
    localparam logic [3:0]    REL_L   = 4'(RELEASE);
    localparam logic [3:0]    GAP_L   = 4'(GAP);
    localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);

    state_t        state;
    logic [1:0]    code;
    logic [3:0]    cnt;
    logic          cap_vld;
    logic [1:0]    cap_code;

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [3:0]    gap;
    logic          pop;
    logic          push;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            code     <= 2'b00;
            cnt      <= 4'd0;
            cap_vld  <= 1'b0;
            cap_code <= 2'b00;
        end else begin
            cap_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (sense != 2'b00) begin
                        state <= QUAL;
                        code  <= sense;
                        cnt   <= 4'd1;
                    end
                end
                QUAL: begin
                    if (sense == 2'b00) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (sense != code) begin
                        code <= sense;
                        cnt  <= 4'd1;
                    end else if (cnt + 4'd1 == DEB_L) begin
                        cap_vld  <= 1'b1;
                        cap_code <= code;
                        state    <= WAIT_REL;
                        cnt      <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WAIT_REL: begin
                    // Any bounce back to non-zero restarts the quiet-period count
                    if (sense != 2'b00) begin
                        cnt <= 4'd0;
                    end else if (cnt + 4'd1 == REL_L) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // A full FIFO can still accept a coin when the head leaves in the same cycle
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        pop  = (count != '0) && !busy && (gap == 4'd0);
        push = cap_vld && ((count != DEPTH_L) || pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            gap    <= 4'd0;
            b1     <= 1'b0;
            b2     <= 1'b0;
            b3     <= 1'b0;
            reject <= 1'b0;
        end else begin
            b1     <= pop && (mem[rd_ptr] == 2'b01);
            b2     <= pop && (mem[rd_ptr] == 2'b10);
            b3     <= pop && (mem[rd_ptr] == 2'b11);
            reject <= cap_vld && !push;

            if (push) begin
                mem[wr_ptr] <= cap_code;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop) begin
                gap <= GAP_L;
            end else if (gap != 4'd0) begin
                gap <= gap - 4'd1;
            end
        end
    end

    assign pending = 4'(count);

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus random sensor/busy traffic,
// checked by a scoreboard fed from a coin-level reference model.
module tb_coin_acceptor;

    localparam int DEBOUNCE = 4;
    localparam int RELEASE  = 2;
    localparam int GAP      = 2;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sense;
    logic       busy;
    logic       b1, b2, b3, reject;
    logic [3:0] pending;

    coin_acceptor #(
        .DEBOUNCE(DEBOUNCE), .RELEASE(RELEASE), .GAP(GAP), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sense(sense), .busy(busy),
        .b1(b1), .b2(b2), .b3(b3), .reject(reject), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] kind;   // {reject, b3, b2, b1}
    } ev_t;

    ev_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 0;

    // Reference model: coins are runs of identical non-zero samples; a run of
    // DEBOUNCE arms a coin, which then needs RELEASE quiet samples to re-arm.
    logic [1:0] mq[$];
    int         gap_left, run_len, zero_len, exp_pending;
    logic [1:0] run_code, cap_c, head;
    bit         armed, cap_v, m_pop, m_push;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            mq.delete();
            sb.delete();
            gap_left = 0; run_len = 0; zero_len = 0; run_code = 2'b00;
            armed = 1; cap_v = 0; cap_c = 2'b00; exp_pending = 0;
        end else begin
            m_pop  = (mq.size() > 0) && !busy && (gap_left == 0);
            m_push = cap_v && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) begin
                head = mq.pop_front();
                sb.push_back('{cyc: cyc, kind: 4'b0001 << (head - 2'd1)});
                gap_left = GAP;
            end else if (gap_left > 0) begin
                gap_left--;
            end
            if (m_push) mq.push_back(cap_c);
            else if (cap_v) sb.push_back('{cyc: cyc, kind: 4'b1000});
            cap_v = 0;

            if (armed) begin
                if (sense == 2'b00) run_len = 0;
                else if (run_len > 0 && sense == run_code) run_len++;
                else begin run_code = sense; run_len = 1; end
                if (run_len == DEBOUNCE) begin
                    cap_v = 1; cap_c = run_code;
                    armed = 0; run_len = 0; zero_len = 0;
                end
            end else begin
                if (sense == 2'b00) zero_len++;
                else zero_len = 0;
                if (zero_len == RELEASE) begin armed = 1; zero_len = 0; end
            end
            exp_pending = mq.size();
        end
    end

    logic [3:0] obs, prev_obs;

    always @(negedge clk) begin
        if (mon_en) begin
            obs = {reject, b3, b2, b1};
            checks++;
            if (pending !== 4'(exp_pending)) begin
                errors++;
                $display("FAIL pending cyc=%0d got=%0d want=%0d", cyc, pending, exp_pending);
            end
            checks++;
            if (!$onehot0(obs) || (obs & prev_obs) != 4'b0000) begin
                errors++;
                $display("FAIL pulse_shape cyc=%0d got=%b prev=%b want=one-hot single-cycle", cyc, obs, prev_obs);
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                errors++;
                $display("FAIL missed_pulse cyc=%0d got=none want=%b@%0d", cyc, sb[0].kind, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (obs != 4'b0000) begin
                checks++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d got=%b want=none", cyc, obs);
                end else begin
                    if (sb[0].kind !== obs) begin
                        errors++;
                        $display("FAIL pulse_kind cyc=%0d got=%b want=%b", cyc, obs, sb[0].kind);
                    end
                    void'(sb.pop_front());
                end
            end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse cyc=%0d got=none want=%b", cyc, sb[0].kind);
                void'(sb.pop_front());
            end
            prev_obs = obs;
        end else begin
            prev_obs = 4'b0000;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] c, input int n);
        sense = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic coin(input logic [1:0] c);
        drive(c, DEBOUNCE);
        drive(2'b00, RELEASE);
    endtask

    initial begin
        bit found;
        int waited;
        rst_n = 1'b0; sense = 2'b00; busy = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1;
        chk("reset_outputs", {b1, b2, b3, reject}, 0);
        chk("reset_pending", pending, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean coin with latency check: first sample at edge 0, b2 at edge 5
        sense = 2'b10;
        repeat (5) @(posedge clk);
        #1 chk("lat_b2_early", b2, 0);
        chk("lat_pending_1", pending, 1);
        @(posedge clk);
        #1 chk("lat_b2_edge5", b2, 1);
        chk("lat_b1b3", {b1, b3}, 0);
        @(posedge clk);
        #1 chk("lat_b2_drop", b2, 0);
        @(negedge clk);
        drive(2'b00, 6);

        // Glitch filter: only one b1
        drive(2'b01, 3); drive(2'b00, 1); drive(2'b11, 2); drive(2'b01, 4);
        drive(2'b00, 12);

        // Busy hold and gap
        busy = 1'b1;
        coin(2'b01); coin(2'b10); coin(2'b11);
        drive(2'b00, 2);
        chk("hold_pending", pending, 3);
        chk("hold_no_pulse", {b1, b2, b3}, 0);
        busy = 1'b0;
        drive(2'b00, 15);

        // Overflow: fifth coin rejected
        busy = 1'b1;
        repeat (5) coin(2'b11);
        drive(2'b00, 2);
        chk("ovf_pending", pending, DEPTH);
        busy = 1'b0;
        drive(2'b00, 20);
        chk("ovf_drained", pending, 0);

        // Simultaneous push and pop at full
        busy = 1'b1;
        repeat (4) coin(2'b01);
        drive(2'b00, 2);
        chk("sim_full", pending, DEPTH);
        sense = 2'b10;
        repeat (4) @(negedge clk);
        busy = 1'b0;
        sense = 2'b00;
        @(negedge clk);
        chk("sim_pending_stays", pending, DEPTH);
        chk("sim_no_reject", reject, 0);
        drive(2'b00, 25);

        // Reset while b2 is high with three coins left
        busy = 1'b1;
        coin(2'b10); coin(2'b11); coin(2'b11); coin(2'b11);
        drive(2'b00, 2);
        busy = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = (b2 == 1'b1);
        end
        chk("rst_b2_seen", found, 1);
        chk("rst_pending_3", pending, 3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {b1, b2, b3, reject}, 0);
        chk("rst_pending", pending, 0);
        rst_n = 1'b1;
        drive(2'b00, 30);

        // Random sensor traffic with random busy
        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(0, 4) == 0) busy = ~busy;
            drive(2'($urandom_range(0, 3)), $urandom_range(1, 7));
        end
        busy = 1'b0;
        sense = 2'b00;
        waited = 0;
        while ((sb.size() > 0 || exp_pending != 0) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        chk("drain_scoreboard", sb.size(), 0);
        chk("drain_pending", pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
